// File: rtl/uart_pkg.sv
// uart_pkg: shared byte width, default FIFO depth and sequencer state encoding
// for the UART transmit FIFO.
package uart_pkg;

    localparam int BYTE_W    = 8;
    localparam int DEF_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } txf_state_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: DEPTH x BYTE_W byte storage with a synchronous write port
// and a combinational read port.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [BYTE_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [BYTE_W-1:0] o_rdata
);

    logic [BYTE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus send sequencer feeding a UART transmitter.
// Optional UART_TX_FIFO_FLUSH_EN adds a synchronous flush input.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              wrEn,
    input  logic [BYTE_W-1:0] wrData,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clrOvf,
    output logic              start,
    output logic [BYTE_W-1:0] txIn,
    input  logic              txDone,
`ifdef UART_TX_FIFO_FLUSH_EN
    input  logic              flush,
`endif
    output logic              busy
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    txf_state_t        r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;
    logic              r_start;
    logic              r_busy;
    logic              r_done_q;
    logic [BYTE_W-1:0] r_tx_byte;

    logic              w_flush;
    logic              w_push;
    logic              w_pop;
    logic              w_done_rise;
    logic [BYTE_W-1:0] w_rd_data;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // full/empty come from the registered count, so a same-cycle pop never frees a slot
    assign full        = r_count == FULL_CNT;
    assign empty       = r_count == '0;
    assign w_push      = wrEn & ~full & ~w_flush;
    assign w_pop       = (r_state == IDLE) & ~empty & ~w_flush;
    assign w_done_rise = txDone & ~r_done_q;

    assign count    = r_count;
    assign overflow = r_ovf;
    assign start    = r_start;
    assign busy     = r_busy;
    assign txIn     = r_tx_byte;

    uart_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (wrData),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_done_q <= 1'b0;
        end else begin
            r_done_q <= txDone;
            if (w_flush)
                r_wr_ptr <= r_rd_ptr;
            else if (w_push)
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_count <= w_flush ? '0 : r_count + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);
            // a dropped write beats a simultaneous clear
            r_ovf   <= (wrEn & full & ~w_flush) | (r_ovf & ~clrOvf);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state   <= IDLE;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_tx_byte <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state   <= LOAD;
                        r_start   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_tx_byte <= w_rd_data;
                    end
                end
                LOAD: begin
                    r_state <= WAIT;
                    r_start <= 1'b0;
                end
                WAIT: begin
                    if (w_done_rise) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_start <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized self-checking bench for uart_tx_fifo with a
// queue-based model of the bytes waiting to be sent.
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk    = 1'b0;
    logic              rstN   = 1'b0;
    logic              wrEn   = 1'b0;
    logic              clrOvf = 1'b0;
    logic              txDone = 1'b0;
    logic [7:0]        wrData = 8'h00;
    logic              full, empty, overflow, start, busy;
    logic [ADDR_W:0]   count;
    logic [7:0]        txIn;
`ifdef UART_TX_FIFO_FLUSH_EN
    logic              flush  = 1'b0;
`endif

    int         errs   = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .wrEn     (wrEn),
        .wrData   (wrData),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .clrOvf   (clrOvf),
        .start    (start),
        .txIn     (txIn),
        .txDone   (txDone),
`ifdef UART_TX_FIFO_FLUSH_EN
        .flush    (flush),
`endif
        .busy     (busy)
    );

    function automatic logic [17:0] snap();
        return {full, empty, overflow, start, busy, count, txIn};
    endfunction

    function automatic logic [ADDR_W:0] qcnt();
        return (ADDR_W+1)'(exp_q.size());
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic retire();
        txDone = 1'b1;
        tick();
        txDone = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL retire_busy: busy=%b want 0", busy);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (start !== 1'b0 || empty !== 1'b1) begin
                errs++;
                $display("FAIL retire_idle: start=%b empty=%b want 0/1", start, empty);
            end
        end
    endtask

    task automatic drain(input int n);
        logic [7:0] want;
        for (int i = 0; i < n; i++) begin
            want = exp_q.size() != 0 ? exp_q[0] : 8'hxx;
            txDone = 1'b1;
            tick();
            txDone = 1'b0;
            tick();
            checks++;
            if (start !== 1'b1 || txIn !== want) begin
                errs++;
                $display("FAIL drain_frame %0d: start=%b txIn=%h want start=1 txIn=%h", i, start, txIn, want);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            checks++;
            if (count !== qcnt()) begin
                errs++;
                $display("FAIL drain_count %0d: count=%0d want %0d", i, count, qcnt());
            end
            tick($urandom_range(1, 3));
        end
        retire();
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        tick(2);
        checks++;
        if (snap() !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00}) begin
            errs++;
            $display("FAIL reset_state: got %h want %h", snap(), {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00});
        end
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (snap() !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00}) begin
                errs++;
                $display("FAIL reset_idle %0d: got %h want %h", i, snap(), {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00});
            end
        end
    endtask

    task automatic test_single();
        wrEn = 1'b1;
        wrData = 8'hA5;
        tick();
        wrEn = 1'b0;
        checks++;
        if (snap() !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 8'h00}) begin
            errs++;
            $display("FAIL single_n1: got %h want %h", snap(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 8'h00});
        end
        tick();
        checks++;
        if (snap() !== {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 8'hA5}) begin
            errs++;
            $display("FAIL single_n2: got %h want %h", snap(), {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 8'hA5});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (snap() !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 8'hA5}) begin
                errs++;
                $display("FAIL single_wait %0d: got %h want %h", i, snap(), {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 8'hA5});
            end
        end
        retire();
    endtask

    task automatic test_fill_overflow();
        wrEn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wrData = 8'h10 + 8'(i);
            if (i > 0) exp_q.push_back(wrData);
            tick();
        end
        checks++;
        if (count !== 5'd15 || full !== 1'b0 || txIn !== 8'h10 || busy !== 1'b1) begin
            errs++;
            $display("FAIL fill_15: count=%0d full=%b txIn=%h busy=%b want 15/0/10/1", count, full, txIn, busy);
        end
        wrData = 8'h20;
        exp_q.push_back(8'h20);
        tick();
        checks++;
        if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
            errs++;
            $display("FAIL fill_full: count=%0d full=%b ovf=%b want 16/1/0", count, full, overflow);
        end
        wrData = 8'hFF;
        tick();
        checks++;
        if (count !== 5'd16 || overflow !== 1'b1) begin
            errs++;
            $display("FAIL overflow_set: count=%0d ovf=%b want 16/1", count, overflow);
        end
        clrOvf = 1'b1;
        tick();
        checks++;
        if (overflow !== 1'b1) begin
            errs++;
            $display("FAIL overflow_set_wins: ovf=%b want 1", overflow);
        end
        wrEn = 1'b0;
        tick();
        clrOvf = 1'b0;
        checks++;
        if (overflow !== 1'b0 || count !== 5'd16 || txIn !== 8'h10) begin
            errs++;
            $display("FAIL overflow_clear: ovf=%b count=%0d txIn=%h want 0/16/10", overflow, count, txIn);
        end
        drain(exp_q.size());
    endtask

    task automatic test_push_pop();
        logic [7:0] first, b;
        first = 8'h00;
        wrEn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            wrData = b;
            if (i == 0) first = b; else exp_q.push_back(b);
            tick();
        end
        wrEn = 1'b0;
        checks++;
        if (count !== 5'd7 || busy !== 1'b1 || txIn !== first) begin
            errs++;
            $display("FAIL pp_setup: count=%0d busy=%b txIn=%h want 7/1/%h", count, busy, txIn, first);
        end
        txDone = 1'b1;
        tick();
        txDone = 1'b0;
        b = 8'($urandom);
        wrEn = 1'b1;
        wrData = b;
        exp_q.push_back(b);
        tick();
        wrEn = 1'b0;
        checks++;
        if (count !== 5'd7 || start !== 1'b1 || txIn !== exp_q[0]) begin
            errs++;
            $display("FAIL pp_same_cycle: count=%0d start=%b txIn=%h want 7/1/%h", count, start, txIn, exp_q[0]);
        end
        void'(exp_q.pop_front());
        tick();
        drain(exp_q.size());
    endtask

    task automatic test_held_done();
        logic [7:0] b0, b1;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        wrEn = 1'b1;
        wrData = b0;
        tick();
        wrData = b1;
        tick();
        wrEn = 1'b0;
        tick();
        txDone = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || start !== 1'b0) begin
            errs++;
            $display("FAIL held_rise: busy=%b start=%b want 0/0", busy, start);
        end
        tick();
        checks++;
        if (start !== 1'b1 || txIn !== b1 || count !== 5'd0) begin
            errs++;
            $display("FAIL held_next_start: start=%b txIn=%h count=%0d want 1/%h/0", start, txIn, count, b1);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (start !== 1'b0 || busy !== 1'b1 || txIn !== b1) begin
                errs++;
                $display("FAIL held_level %0d: start=%b busy=%b txIn=%h want 0/1/%h", i, start, busy, txIn, b1);
            end
        end
        txDone = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL held_fall: busy=%b want 1", busy);
        end
        drain(0);
    endtask

    task automatic test_wrap();
        int sent = 0, got = 0, cd = 0, cyc = 0;
        logic [7:0] b;
        while (got < 40 && cyc < 3000) begin
            if (start === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || txIn !== exp_q[0]) begin
                    errs++;
                    $display("FAIL wrap_byte %0d: txIn=%h want %h", got, txIn, exp_q.size() != 0 ? exp_q[0] : 8'hxx);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
                cd = int'($urandom_range(2, 6));
            end
            checks++;
            if (count !== qcnt()) begin
                errs++;
                $display("FAIL wrap_count: count=%0d want %0d", count, qcnt());
            end
            txDone = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) txDone = 1'b1;
            end
            wrEn = 1'b0;
            if (sent < 40 && exp_q.size() < 12 && $urandom_range(0, 1) == 1) begin
                b = 8'($urandom);
                wrEn = 1'b1;
                wrData = b;
                exp_q.push_back(b);
                sent++;
            end
            tick();
            cyc++;
        end
        wrEn = 1'b0;
        txDone = 1'b0;
        checks++;
        if (got != 40) begin
            errs++;
            $display("FAIL wrap_timeout: frames=%0d want 40", got);
        end
        tick();
        retire();
    endtask

    task automatic test_midreset();
        wrEn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wrData = 8'($urandom);
            tick();
        end
        wrEn = 1'b0;
        #2 rstN = 1'b0;
        #1;
        checks++;
        if (snap() !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00}) begin
            errs++;
            $display("FAIL midreset_async: got %h want %h", snap(), {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00});
        end
        tick();
        rstN = 1'b1;
        exp_q.delete();
        tick();
        txDone = 1'b1;
        tick();
        txDone = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (start !== 1'b0 || busy !== 1'b0 || empty !== 1'b1) begin
                errs++;
                $display("FAIL midreset_quiet %0d: start=%b busy=%b empty=%b want 0/0/1", i, start, busy, empty);
            end
        end
    endtask

`ifdef UART_TX_FIFO_FLUSH_EN
    task automatic test_flush();
        logic [7:0] b0;
        b0 = 8'($urandom);
        wrEn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wrData = i == 0 ? b0 : 8'($urandom);
            tick();
        end
        wrEn = 1'b0;
        tick();
        checks++;
        if (count !== 5'd4 || busy !== 1'b1) begin
            errs++;
            $display("FAIL flush_setup: count=%0d busy=%b want 4/1", count, busy);
        end
        flush = 1'b1;
        wrEn = 1'b1;
        wrData = 8'($urandom);
        tick();
        flush = 1'b0;
        wrEn = 1'b0;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || busy !== 1'b1 || txIn !== b0 || overflow !== 1'b0) begin
            errs++;
            $display("FAIL flush_apply: count=%0d empty=%b busy=%b txIn=%h ovf=%b want 0/1/1/%h/0",
                     count, empty, busy, txIn, overflow, b0);
        end
        tick(2);
        retire();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_push_pop();
        test_held_done();
        test_wrap();
        test_midreset();
`ifdef UART_TX_FIFO_FLUSH_EN
        test_flush();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
